axi2apb_ctrl: RTL and testbench
===============================

// Module: axi2apb_ctrl
// PURPOSE
//  Command scheduler for the AXI-to-APB bridge. Arbitrates single-beat AXI AW and AR commands
//  round-robin, decodes the target slave and sequences the APB SETUP/ACCESS phases.
//  Holds each command until the write-response or read-response path reports completion.
//  Sits between the AXI slave port and the axi2apb write/read response paths and the APB mux.
// PARAMETERS
//  ADDR_BITS   32  AXI address width
//  ID_BITS     4   AXI ID width
//  PADDR_BITS  16  APB address width; paddr = addr[PADDR_BITS-1:0]
//  SLV_BITS    3   decode field width; field = addr[ADDR_BITS-1 -: SLV_BITS]
//  NUM_SLV     6   implemented slaves; field >= NUM_SLV is a decode error
// PORTS
//  clk        in   1           clock
//  reset      in   1           asynchronous reset, active-low (0 = in reset)
//  AWID/ARID  in   ID_BITS     command IDs
//  AWADDR     in   ADDR_BITS   write address
//  ARADDR     in   ADDR_BITS   read address
//  AWVALID    in   1           write command valid
//  ARVALID    in   1           read command valid
//  AWREADY    out  1           write command accepted
//  ARREADY    out  1           read command accepted
//  WVALID     in   1           write data present (WREADY is owned by the wr path)
//  finish_wr  in   1           write response handshake done
//  finish_rd  in   1           read response handshake done
//  cmd_id     out  ID_BITS     latched ID of the active command
//  cmd_err    out  1           active command failed decode
//  cmd_read   out  1           active command is a read
//  psel       out  1           APB select
//  penable    out  1           APB enable
//  pwrite     out  1           APB direction
//  paddr      out  PADDR_BITS  APB address
//  pslv       out  NUM_SLV     one-hot slave select; all-zero on decode error
//  pready     in   1           APB ready (the mux returns 1 when pslv == 0)
// BEHAVIOUR
//  - Reset: state = IDLE; all outputs 0; last_wr = 0, so a write wins the first tie.
//  - FSM: IDLE -> WAIT_W -> SETUP -> ACCESS -> WAIT_FIN -> IDLE.
//  - IDLE:
//     - AWREADY = AWVALID & (~ARVALID | ~last_wr), combinational.
//     - ARREADY = ARVALID & ~AWREADY, combinational.
//     - On a handshake: latch id, addr and err; set cmd_read; update last_wr.
//     - Next state: write -> WAIT_W; read -> SETUP.
//  - WAIT_W: leave for SETUP in the first cycle WVALID = 1.
//  - SETUP: psel = 1, penable = 0 for exactly one cycle, then ACCESS.
//  - ACCESS: psel = penable = 1; hold until pready = 1, then go to WAIT_FIN with psel = penable = 0.
//  - WAIT_FIN: wait for finish_wr (write) or finish_rd (read); the other finish is ignored. Then IDLE.
//  - Latency: at most one command in flight. AW handshake at cycle N with WVALID = 1 gives:
//     - WAIT_W at N+1
//     - SETUP at N+2
//     - ACCESS at N+3
//  - Outputs hold stable while psel = 1: pwrite = ~cmd_read, paddr, pslv, cmd_id, cmd_err.
//  - cmd_err = 1: the APB cycle still runs with pslv = 0, so the response paths report SLVERR.
//  - Finish arriving in the same cycle as pready is illegal; assert it.
//  - Reset asserted mid-transfer: return to IDLE immediately and drop psel/penable.
// STRUCTURE
//  - Shared package: state encoding (3-bit localparams) and decode helper function.
//  - Sub-module axi2apb_rr_arb: 2-input round-robin arbiter holding last_wr.
// TESTING
//  1. AWVALID only, addr 0x2000_0010, WVALID = 1:
//     - AWREADY at N; psel at N+2; penable at N+3
//     - pslv = 6'b000010, paddr = 0x0010, pwrite = 1
//  2. AWVALID and ARVALID together from reset:
//     - write granted first, then the read
//     - next tie is granted to the write again (alternation)
//  3. Addr 0xE000_0000 (field 7 >= 6):
//     - cmd_err = 1, pslv = 0, APB cycle completes
//     - BRESP = 2'b10
//  4. pready held low 5 cycles: psel/penable/paddr stable, then WAIT_FIN until finish_wr.
//  5. Write with WVALID delayed 4 cycles: FSM stays in WAIT_W, psel = 0, no new AR accepted.
//  6. Reset driven low during ACCESS: outputs 0 next edge; a fresh command then completes.

Source files
------------

// File: rtl/axi2apb_ctrl_pkg.sv
// Shared definitions for the AXI-to-APB command scheduler.
//   - 3-bit state encoding of the scheduler FSM
//   - decode_err(): true when a slave decode field has no implemented slave
package axi2apb_ctrl_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_W   = 3'd1;
    localparam logic [2:0] ST_SETUP    = 3'd2;
    localparam logic [2:0] ST_ACCESS   = 3'd3;
    localparam logic [2:0] ST_WAIT_FIN = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_WAIT_W   = ST_WAIT_W,
        S_SETUP    = ST_SETUP,
        S_ACCESS   = ST_ACCESS,
        S_WAIT_FIN = ST_WAIT_FIN
    } state_e;

    function automatic logic decode_err(input int field, input int num_slv);
        return field >= num_slv;
    endfunction

endpackage

// File: rtl/axi2apb_rr_arb.sv
// Two-input round-robin arbiter between the AXI write (AW) and read (AR)
// command channels.
//   clk, reset  : clock, asynchronous active-low reset
//   en_i        : scheduler can accept a command this cycle
//   req_wr_i    : AWVALID
//   req_rd_i    : ARVALID
//   gnt_wr_o    : write command granted (combinational)
//   gnt_rd_o    : read command granted (combinational)
module axi2apb_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic req_wr_i,
    input  logic req_rd_i,
    output logic gnt_wr_o,
    output logic gnt_rd_o
);

    // last_wr_q = 1 when the most recent grant went to the write channel.
    // It resets to 0 so the first tie goes to the write.
    logic last_wr_q, last_wr_d;

    assign gnt_wr_o = en_i & req_wr_i & (~req_rd_i | ~last_wr_q);
    assign gnt_rd_o = en_i & req_rd_i & ~gnt_wr_o;

    always_comb begin
        last_wr_d = last_wr_q;
        if (gnt_wr_o) begin
            last_wr_d = 1'b1;
        end else if (gnt_rd_o) begin
            last_wr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_wr_q <= 1'b0;
        end else begin
            last_wr_q <= last_wr_d;
        end
    end

endmodule

// File: rtl/axi2apb_ctrl.sv
// Command scheduler of the AXI-to-APB bridge. Accepts one single-beat AW or
// AR command at a time (round-robin), decodes the target slave, runs the APB
// SETUP/ACCESS phases and holds the command until the matching response path
// reports completion.
//   clk, reset            : clock, asynchronous active-low reset
//   AWID/AWADDR/AWVALID   : write command in;  AWREADY out
//   ARID/ARADDR/ARVALID   : read command in;   ARREADY out
//   WVALID                : write data present (gates the write APB cycle)
//   finish_wr/finish_rd   : response handshake done on the wr/rd path
//   cmd_id/cmd_err/cmd_read : attributes of the active command
//   psel/penable/pwrite/paddr/pslv : APB master side, pready : APB ready
module axi2apb_ctrl
    import axi2apb_ctrl_pkg::*;
#(
    parameter int ADDR_BITS  = 32,
    parameter int ID_BITS    = 4,
    parameter int PADDR_BITS = 16,
    parameter int SLV_BITS   = 3,
    parameter int NUM_SLV    = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ID_BITS-1:0]    AWID,
    input  logic [ADDR_BITS-1:0]  AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [ID_BITS-1:0]    ARID,
    input  logic [ADDR_BITS-1:0]  ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic                  WVALID,
    input  logic                  finish_wr,
    input  logic                  finish_rd,
    output logic [ID_BITS-1:0]    cmd_id,
    output logic                  cmd_err,
    output logic                  cmd_read,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [PADDR_BITS-1:0] paddr,
    output logic [NUM_SLV-1:0]    pslv,
    input  logic                  pready
);

    state_e                  state_q, state_d;
    logic [ID_BITS-1:0]      id_q, id_d;
    logic [PADDR_BITS-1:0]   paddr_q, paddr_d;
    logic [NUM_SLV-1:0]      pslv_q, pslv_d;
    logic                    err_q, err_d;
    logic                    read_q, read_d;
    logic                    pwrite_q, pwrite_d;

    logic                    idle;
    logic                    gnt_wr, gnt_rd;
    logic [ADDR_BITS-1:0]    sel_addr;
    logic [SLV_BITS-1:0]     field;
    logic                    field_err;
    logic [NUM_SLV-1:0]      field_onehot;
    logic                    unused_addr_mid;

    assign idle = (state_q == S_IDLE);

    axi2apb_rr_arb u_arb (
        .clk      (clk),
        .reset    (reset),
        .en_i     (idle),
        .req_wr_i (AWVALID),
        .req_rd_i (ARVALID),
        .gnt_wr_o (gnt_wr),
        .gnt_rd_o (gnt_rd)
    );

    assign AWREADY = gnt_wr;
    assign ARREADY = gnt_rd;

    // Decode the granted command's address.
    assign sel_addr  = gnt_wr ? AWADDR : ARADDR;
    assign field     = sel_addr[ADDR_BITS-1 -: SLV_BITS];
    assign field_err = decode_err(int'(field), NUM_SLV);

    // Address bits between the APB window and the decode field carry no meaning here.
    assign unused_addr_mid = ^sel_addr[ADDR_BITS-SLV_BITS-1:PADDR_BITS];

    // A decode error leaves pslv all-zero so the APB mux answers with an error.
    always_comb begin
        field_onehot = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            field_onehot[i] = (int'(field) == i) && !field_err;
        end
    end

    // Command attributes are captured only at the handshake, which keeps them
    // stable for the whole APB cycle and the response phase.
    always_comb begin
        id_d     = id_q;
        paddr_d  = paddr_q;
        pslv_d   = pslv_q;
        err_d    = err_q;
        read_d   = read_q;
        pwrite_d = pwrite_q;
        if (gnt_wr || gnt_rd) begin
            id_d     = gnt_wr ? AWID : ARID;
            paddr_d  = sel_addr[PADDR_BITS-1:0];
            pslv_d   = field_onehot;
            err_d    = field_err;
            read_d   = gnt_rd;
            pwrite_d = gnt_wr;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_wr) begin
                    state_d = S_WAIT_W;
                end else if (gnt_rd) begin
                    state_d = S_SETUP;
                end
            end
            S_WAIT_W: begin
                if (WVALID) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    state_d = S_WAIT_FIN;
                end
            end
            S_WAIT_FIN: begin
                // Only the finish of the active command's own path counts.
                if (read_q ? finish_rd : finish_wr) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            id_q     <= '0;
            paddr_q  <= '0;
            pslv_q   <= '0;
            err_q    <= 1'b0;
            read_q   <= 1'b0;
            pwrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            paddr_q  <= paddr_d;
            pslv_q   <= pslv_d;
            err_q    <= err_d;
            read_q   <= read_d;
            pwrite_q <= pwrite_d;
        end
    end

    assign psel     = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign penable  = (state_q == S_ACCESS);
    assign pwrite   = pwrite_q;
    assign paddr    = paddr_q;
    assign pslv     = pslv_q;
    assign cmd_id   = id_q;
    assign cmd_err  = err_q;
    assign cmd_read = read_q;

    // A response path cannot complete before its APB transfer has ended.
    finish_vs_pready: assert property (@(posedge clk) disable iff (!reset)
        !((state_q == S_ACCESS) && pready && (finish_wr || finish_rd)));

endmodule

// File: tb/tb_axi2apb_ctrl.sv
module tb_axi2apb_ctrl;

    localparam int ADDR_BITS  = 32;
    localparam int ID_BITS    = 4;
    localparam int PADDR_BITS = 16;
    localparam int SLV_BITS   = 3;
    localparam int NUM_SLV    = 6;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [ID_BITS-1:0]    AWID, ARID;
    logic [ADDR_BITS-1:0]  AWADDR, ARADDR;
    logic                  AWVALID, ARVALID, AWREADY, ARREADY;
    logic                  WVALID, finish_wr, finish_rd;
    logic [ID_BITS-1:0]    cmd_id;
    logic                  cmd_err, cmd_read;
    logic                  psel, penable, pwrite;
    logic [PADDR_BITS-1:0] paddr;
    logic [NUM_SLV-1:0]    pslv;
    logic                  pready;

    always #5 clk = ~clk;

    axi2apb_ctrl #(
        .ADDR_BITS  (ADDR_BITS),
        .ID_BITS    (ID_BITS),
        .PADDR_BITS (PADDR_BITS),
        .SLV_BITS   (SLV_BITS),
        .NUM_SLV    (NUM_SLV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .AWID      (AWID),
        .AWADDR    (AWADDR),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .ARID      (ARID),
        .ARADDR    (ARADDR),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .WVALID    (WVALID),
        .finish_wr (finish_wr),
        .finish_rd (finish_rd),
        .cmd_id    (cmd_id),
        .cmd_err   (cmd_err),
        .cmd_read  (cmd_read),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pslv      (pslv),
        .pready    (pready)
    );

    typedef struct {
        logic        wr;
        logic [15:0] paddr;
        logic [5:0]  pslv;
        logic [3:0]  id;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   m_last_wr = 1'b0;   // reference: was the last grant a write?

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endfunction

    function automatic void fail(string name);
        total++;
        bad++;
        $display("FAIL %s: event missing", name);
    endfunction

    // Expected APB view of a command, straight from the address map rules.
    function automatic exp_t mk_exp(bit wr, logic [31:0] addr, logic [3:0] id);
        exp_t e;
        int   fld;
        fld     = int'(addr[31:29]);
        e.wr    = wr;
        e.paddr = addr[15:0];
        e.id    = id;
        e.err   = (fld >= NUM_SLV);
        e.pslv  = e.err ? 6'd0 : 6'(1 << fld);
        return e;
    endfunction

    // Monitor: pops one expectation per APB SETUP phase and checks it is held
    // through ACCESS.
    exp_t cur;
    bit   prev_setup = 1'b0;
    bit   in_apb     = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            prev_setup = 1'b0;
            in_apb     = 1'b0;
        end else begin
            if (prev_setup) chk("access_follows_setup", 32'({psel, penable}), 32'(2'b11));
            prev_setup = 1'b0;
            if (psel && !penable) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_setup");
                end else begin
                    cur        = exp_q.pop_front();
                    in_apb     = 1'b1;
                    prev_setup = 1'b1;
                    chk("pwrite",   32'(pwrite),   32'(cur.wr));
                    chk("cmd_read", 32'(cmd_read), 32'(!cur.wr));
                    chk("paddr",    32'(paddr),    32'(cur.paddr));
                    chk("pslv",     32'(pslv),     32'(cur.pslv));
                    chk("cmd_id",   32'(cmd_id),   32'(cur.id));
                    chk("cmd_err",  32'(cmd_err),  32'(cur.err));
                end
            end else if (psel && penable) begin
                if (!in_apb) fail("setup_before_access");
                else chk("access_hold",
                         32'({pwrite, paddr, pslv, cmd_id, cmd_err}),
                         32'({cur.wr, cur.paddr, cur.pslv, cur.id, cur.err}));
            end else begin
                in_apb = 1'b0;
            end
        end
    end

    // One round presents an AW and/or AR command, serves W, APB and finish
    // for each command in turn. rst_mid pulls reset during ACCESS (single command only).
    task automatic run_round(input bit do_aw, input logic [31:0] awa, input logic [3:0] awi,
                             input bit do_ar, input logic [31:0] ara, input logic [3:0] ari,
                             input int wdly, input int pdly, input bit rst_mid);
        bit order[$];
        if (do_aw && do_ar) begin
            if (m_last_wr) begin order.push_back(1'b0); order.push_back(1'b1); end
            else           begin order.push_back(1'b1); order.push_back(1'b0); end
        end else begin
            order.push_back(do_aw);
        end
        foreach (order[k]) exp_q.push_back(order[k] ? mk_exp(1'b1, awa, awi) : mk_exp(1'b0, ara, ari));
        m_last_wr = order[order.size()-1];

        @(negedge clk);
        AWVALID = do_aw; AWADDR = awa; AWID = awi;
        ARVALID = do_ar; ARADDR = ara; ARID = ari;

        foreach (order[k]) begin
            int t;
            int lat;
            int fdly;
            bit got;
            bit hs_wr;
            bit seen;
            t = 0; got = 1'b0; hs_wr = 1'b0;
            while (!got) begin
                #1;
                if (AWVALID && AWREADY) begin got = 1'b1; hs_wr = 1'b1; end
                else if (ARVALID && ARREADY) begin got = 1'b1; hs_wr = 1'b0; end
                else begin
                    t++;
                    if (t > 40) begin
                        fail("handshake_timeout");
                        AWVALID = 1'b0; ARVALID = 1'b0;
                        return;
                    end
                    @(negedge clk);
                end
            end
            chk("single_grant", 32'(AWREADY & ARREADY), 32'd0);
            chk("grant_order", 32'(hs_wr), 32'(order[k]));

            lat = 0; seen = 1'b0;
            while (!seen) begin
                @(negedge clk);
                lat++;
                if (lat == 1) begin
                    if (hs_wr) AWVALID = 1'b0; else ARVALID = 1'b0;
                end
                WVALID = hs_wr && (lat > wdly);
                #1;
                if (psel) begin
                    seen = 1'b1;
                end else begin
                    if (AWVALID || ARVALID) chk("busy_no_accept", 32'(AWREADY | ARREADY), 32'd0);
                    if (lat > 40) begin
                        fail("setup_timeout");
                        WVALID = 1'b0; AWVALID = 1'b0; ARVALID = 1'b0;
                        return;
                    end
                end
            end
            chk("setup_latency", 32'(lat), 32'(hs_wr ? 2 + wdly : 1));

            @(negedge clk);
            WVALID = 1'b0;
            if (rst_mid) begin
                reset = 1'b0;
                #1;
                chk("mid_rst_ctrl", 32'({psel, penable, pwrite, cmd_read, cmd_err}), 32'd0);
                chk("mid_rst_paddr", 32'(paddr), 32'd0);
                chk("mid_rst_pslv", 32'(pslv), 32'd0);
                @(negedge clk);
                reset = 1'b1;
                m_last_wr = 1'b0;
                return;
            end

            repeat (pdly) @(negedge clk);
            pready = 1'b1;
            @(negedge clk);
            pready = 1'b0;
            #1 chk("wait_fin_bus_idle", 32'({psel, penable}), 32'd0);

            fdly = $urandom_range(0, 3);
            for (int i = 0; i < fdly; i++) begin
                @(negedge clk);
                if (hs_wr) finish_rd = 1'($urandom_range(0, 1));
                else       finish_wr = 1'($urandom_range(0, 1));
                #1;
                if (AWVALID || ARVALID) chk("wait_fin_hold", 32'(AWREADY | ARREADY), 32'd0);
            end
            @(negedge clk);
            finish_wr = hs_wr;
            finish_rd = !hs_wr;
            #1;
            if (AWVALID || ARVALID) chk("wait_fin_hold", 32'(AWREADY | ARREADY), 32'd0);
            @(negedge clk);
            finish_wr = 1'b0;
            finish_rd = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        AWVALID = 1'b0; ARVALID = 1'b0; AWADDR = '0; ARADDR = '0; AWID = '0; ARID = '0;
        WVALID = 1'b0; finish_wr = 1'b0; finish_rd = 1'b0; pready = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ctrl", 32'({psel, penable, pwrite, cmd_read, cmd_err, AWREADY, ARREADY}), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_pslv", 32'(pslv), 32'd0);
        chk("rst_cmd_id", 32'(cmd_id), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Ties from reset: write, then read, and the next tie goes to the write again.
        run_round(1'b1, 32'h4000_0100, 4'h3, 1'b1, 32'h0000_0200, 4'h5, 0, 0, 1'b0);
        run_round(1'b1, 32'h6000_0300, 4'h7, 1'b1, 32'h2000_0400, 4'h9, 1, 1, 1'b0);
        // Plain write to slave 1.
        run_round(1'b1, 32'h2000_0010, 4'h1, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0);
        // Decode error (field 7).
        run_round(1'b1, 32'hE000_0000, 4'hA, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0);
        // Slow slave: pready low for 5 ACCESS cycles.
        run_round(1'b1, 32'h8000_1234, 4'h2, 1'b0, 32'h0, 4'h0, 0, 5, 1'b0);
        // Read alone, so the following tie goes to the write.
        run_round(1'b0, 32'h0, 4'h0, 1'b1, 32'hA000_00F0, 4'hC, 0, 1, 1'b0);
        // Write waiting 4 cycles for WVALID while a read is pending.
        run_round(1'b1, 32'h0000_0044, 4'h6, 1'b1, 32'h2000_0088, 4'hB, 4, 0, 1'b0);
        // Reset during ACCESS, then fresh commands.
        run_round(1'b1, 32'h4000_0500, 4'hD, 1'b0, 32'h0, 4'h0, 0, 0, 1'b1);
        run_round(1'b1, 32'h6000_0600, 4'hE, 1'b1, 32'h8000_0700, 4'hF, 0, 0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            bit aw, ar;
            aw = 1'($urandom_range(0, 1));
            ar = aw ? 1'($urandom_range(0, 1)) : 1'b1;
            run_round(aw, $urandom, 4'($urandom), ar, $urandom, 4'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
